// File: rtl/boot_loader_pkg.sv
// Shared constants, state encoding and helpers for the UART boot-memory loader.
`timescale 1ns/1ps
package boot_loader_pkg;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam logic [7:0] CMD_WRITE    = 8'h01;
  localparam logic [7:0] CMD_GO       = 8'h02;
  localparam logic [7:0] ACK_BYTE     = 8'h06;
  localparam logic [7:0] NAK_BYTE     = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    CSUM,
    WRITE,
    RESP,
    RUN
  } loader_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte timeout: reloads on clear, counts down while enabled, pulses on terminal count.
`timescale 1ns/1ps
module loader_timeout #(
  parameter int TIMEOUT_CYCLES = 80000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (i_clr) begin
      cnt <= LOAD;
    end else if (i_en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // A byte arriving in the expiry cycle wins over the timeout.
  assign o_expired = i_en && !i_clr && (cnt == '0);

endmodule

// File: rtl/boot_mem_uart_loader.sv
// Parses framed UART write/GO commands into boot-memory writes and holds the CPU until GO.
//
// state | meaning
// IDLE  | hunting for SYNC byte
// CMD   | waiting for command byte
// ADDR  | collecting 4 address bytes, MSB first
// DATA  | collecting 4 data bytes, MSB first
// CSUM  | waiting for checksum byte, frame judged on arrival
// WRITE | single-cycle memory write strobe
// RESP  | holding ACK/NAK until TX accepts it
// RUN   | CPU released, loader inert until reset
`timescale 1ns/1ps
module boot_mem_uart_loader
  import boot_loader_pkg::*;
#(
  parameter int         MEM_AW         = 11,
  parameter int         TIMEOUT_CYCLES = 80000,
  parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  output logic              o_tx_valid,
  output logic [7:0]        o_tx_data,
  input  logic              i_tx_ready,
  output logic              o_mem_we,
  output logic [MEM_AW-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_cpu_hold,
  output logic              o_busy,
  output logic [15:0]       o_word_count,
  output logic [7:0]        o_err_count
);

  loader_state_t state;
  logic [7:0]    cmd_q;
  logic [31:0]   addr_q;
  logic [31:0]   data_q;
  logic [7:0]    csum_q;
  logic [1:0]    idx;
  logic          go_q;

  logic in_frame;
  logic byte_taken;
  logic tmo_expired;
  logic cmd_known;
  logic addr_ok;
  logic frame_ok;

  assign in_frame   = (state == CMD) || (state == ADDR) || (state == DATA) || (state == CSUM);
  assign byte_taken = i_rx_valid && (in_frame || (state == IDLE));

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (byte_taken),
    .i_en     (in_frame),
    .o_expired(tmo_expired)
  );

  assign cmd_known = (cmd_q == CMD_WRITE) || (cmd_q == CMD_GO);
  assign addr_ok   = ((addr_q >> (MEM_AW + 2)) == 32'd0) && (addr_q[1:0] == 2'b00);
  assign frame_ok  = (csum_q == i_rx_data) && cmd_known && ((cmd_q != CMD_WRITE) || addr_ok);

  assign o_busy = (state != IDLE) && (state != RUN);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      cmd_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      csum_q       <= '0;
      idx          <= '0;
      go_q         <= 1'b0;
      o_tx_valid   <= 1'b0;
      o_tx_data    <= '0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
      o_cpu_hold   <= 1'b1;
      o_word_count <= '0;
      o_err_count  <= '0;
    end else begin
      o_mem_we <= 1'b0;
      if (tmo_expired) begin
        state       <= IDLE;
        o_err_count <= sat_inc8(o_err_count);
      end else begin
        case (state)
          IDLE: if (i_rx_valid && (i_rx_data == SYNC_BYTE)) state <= CMD;
          CMD: if (i_rx_valid) begin
            cmd_q  <= i_rx_data;
            csum_q <= i_rx_data;
            idx    <= '0;
            state  <= ADDR;
          end
          ADDR: if (i_rx_valid) begin
            addr_q <= {addr_q[23:0], i_rx_data};
            csum_q <= csum_q ^ i_rx_data;
            idx    <= idx + 2'd1;
            if (idx == 2'd3) state <= DATA;
          end
          DATA: if (i_rx_valid) begin
            data_q <= {data_q[23:0], i_rx_data};
            csum_q <= csum_q ^ i_rx_data;
            idx    <= idx + 2'd1;
            if (idx == 2'd3) state <= CSUM;
          end
          CSUM: if (i_rx_valid) begin
            if (frame_ok && (cmd_q == CMD_WRITE)) begin
              state        <= WRITE;
              o_mem_we     <= 1'b1;
              o_mem_addr   <= addr_q[MEM_AW+1:2];
              o_mem_wdata  <= data_q;
              o_word_count <= o_word_count + 16'd1;
            end else begin
              state      <= RESP;
              o_tx_valid <= 1'b1;
              o_tx_data  <= frame_ok ? ACK_BYTE : NAK_BYTE;
              go_q       <= frame_ok;
              if (!frame_ok) o_err_count <= sat_inc8(o_err_count);
            end
          end
          WRITE: begin
            state      <= RESP;
            o_tx_valid <= 1'b1;
            o_tx_data  <= ACK_BYTE;
            go_q       <= 1'b0;
          end
          RESP: if (i_tx_ready) begin
            o_tx_valid <= 1'b0;
            if (go_q) begin
              state      <= RUN;
              o_cpu_hold <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
          RUN: state <= RUN;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_boot_mem_uart_loader.sv
// Directed bench for the UART boot loader: table of frames plus timeout, GO, reset and saturation sequences.
`timescale 1ns/1ps
module tb_boot_mem_uart_loader;

  localparam int TO = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;
  logic        mem_we;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic [15:0] word_count;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  boot_mem_uart_loader #(.MEM_AW(11), .TIMEOUT_CYCLES(TO), .SYNC_BYTE(8'hA5)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
    .o_tx_valid(tx_valid), .o_tx_data(tx_data), .i_tx_ready(tx_ready),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_cpu_hold(cpu_hold), .o_busy(busy), .o_word_count(word_count), .o_err_count(err_count)
  );

  int          tests = 0;
  int          fails = 0;
  int          we_cnt = 0;
  int          tx_cnt = 0;
  logic [10:0] last_addr = '0;
  logic [31:0] last_wdata = '0;
  logic [7:0]  last_tx = '0;

  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt++;
      last_addr  = mem_addr;
      last_wdata = mem_wdata;
    end
    if (tx_valid && tx_ready) begin
      tx_cnt++;
      last_tx = tx_data;
    end
  end

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  csum;
    logic        exp_we;
    logic [10:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [7:0]  exp_tx;
  } frame_vec_t;

  frame_vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr,
                            input logic [31:0] data, input logic [7:0] csum);
    send_byte(8'hA5);
    send_byte(cmd);
    for (int i = 3; i >= 0; i--) send_byte(addr[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) send_byte(data[i*8 +: 8]);
    send_byte(csum);
  endtask

  initial begin
    int we0, tx0, err0, wc0, bad;

    vecs[0] = '{8'h01, 32'h0000_0010, 32'hE3A0_0000, 8'h52, 1'b1, 11'h004, 32'hE3A0_0000, 8'h06};
    vecs[1] = '{8'h01, 32'h0000_0010, 32'hE3A0_0000, 8'h53, 1'b0, 11'h000, 32'h0,         8'h15};
    vecs[2] = '{8'h01, 32'h0000_2000, 32'h0000_0000, 8'h21, 1'b0, 11'h000, 32'h0,         8'h15};
    vecs[3] = '{8'h01, 32'h0000_0002, 32'h0000_0000, 8'h03, 1'b0, 11'h000, 32'h0,         8'h15};
    vecs[4] = '{8'h03, 32'h0000_0000, 32'h0000_0000, 8'h03, 1'b0, 11'h000, 32'h0,         8'h15};
    vecs[5] = '{8'h01, 32'h0000_1FFC, 32'hA5A5_A5A5, 8'hE2, 1'b1, 11'h7FF, 32'hA5A5_A5A5, 8'h06};
    vecs[6] = '{8'h01, 32'h0000_0000, 32'h1234_5678, 8'h09, 1'b1, 11'h000, 32'h1234_5678, 8'h06};
    vecs[7] = '{8'h01, 32'h8000_0000, 32'h0000_0000, 8'h81, 1'b0, 11'h000, 32'h0,         8'h15};

    repeat (3) tick();
    rst = 1'b0;
    check("rst_hold", cpu_hold, 1);
    check("rst_busy", busy, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_word_count", word_count, 0);
    check("rst_err_count", err_count, 0);

    foreach (vecs[v]) begin
      we0 = we_cnt; tx0 = tx_cnt; err0 = err_count; wc0 = word_count;
      send_frame(vecs[v].cmd, vecs[v].addr, vecs[v].data, vecs[v].csum);
      repeat (5) tick();
      check($sformatf("v%0d_we_pulses", v), we_cnt - we0, vecs[v].exp_we);
      check($sformatf("v%0d_tx_count", v), tx_cnt - tx0, 1);
      check($sformatf("v%0d_tx_byte", v), last_tx, vecs[v].exp_tx);
      check($sformatf("v%0d_word_delta", v), 16'(word_count - wc0), vecs[v].exp_we);
      check($sformatf("v%0d_err_delta", v), err_count - err0, !vecs[v].exp_we);
      if (vecs[v].exp_we) begin
        check($sformatf("v%0d_addr", v), last_addr, vecs[v].exp_addr);
        check($sformatf("v%0d_wdata", v), last_wdata, vecs[v].exp_wdata);
      end
      check($sformatf("v%0d_idle", v), busy, 0);
    end

    // Cycle-exact write/response timing.
    send_frame(8'h01, 32'h0000_0020, 32'hCAFE_BABE, 8'h11);
    check("lat_we_n1", mem_we, 1);
    check("lat_addr_n1", mem_addr, 11'h008);
    check("lat_wdata_n1", mem_wdata, 32'hCAFE_BABE);
    check("lat_txv_n1", tx_valid, 0);
    tick();
    check("lat_we_n2", mem_we, 0);
    check("lat_txv_n2", tx_valid, 1);
    check("lat_tx_n2", tx_data, 8'h06);
    repeat (3) tick();

    // Inter-byte timeout with exact expiry cycle.
    err0 = err_count; tx0 = tx_cnt;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    repeat (TO - 1) tick();
    check("tmo_busy_before", busy, 1);
    tick();
    check("tmo_busy_after", busy, 0);
    check("tmo_err_delta", err_count - err0, 1);
    check("tmo_no_tx", tx_cnt - tx0, 0);
    we0 = we_cnt;
    send_frame(vecs[0].cmd, vecs[0].addr, vecs[0].data, vecs[0].csum);
    repeat (5) tick();
    check("tmo_next_we", we_cnt - we0, 1);
    check("tmo_next_tx", last_tx, 8'h06);

    // GO with TX stalled for 10 cycles.
    tx_ready = 1'b0;
    send_frame(8'h02, 32'h0, 32'h0, 8'h02);
    check("go_txv", tx_valid, 1);
    bad = 0;
    repeat (10) begin
      tick();
      if (!(tx_valid && tx_data == 8'h06 && cpu_hold)) bad++;
    end
    check("go_stall_stable", bad, 0);
    tx_ready = 1'b1;
    tick();
    check("go_hold_fell", cpu_hold, 0);
    check("go_txv_drop", tx_valid, 0);
    check("go_run_busy", busy, 0);
    tick();
    we0 = we_cnt; tx0 = tx_cnt; wc0 = word_count;
    send_frame(vecs[0].cmd, vecs[0].addr, vecs[0].data, vecs[0].csum);
    repeat (5) tick();
    check("run_no_we", we_cnt - we0, 0);
    check("run_no_tx", tx_cnt - tx0, 0);
    check("run_word_same", word_count, wc0);

    // Reset from RUN, then reset mid-frame.
    rst = 1'b1;
    #1;
    check("rst_run_hold", cpu_hold, 1);
    tick();
    rst = 1'b0;
    tick();
    send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
    send_byte(8'hE3);
    check("mid_busy_pre", busy, 1);
    rst = 1'b1;
    #2;
    check("mid_busy", busy, 0);
    check("mid_hold", cpu_hold, 1);
    check("mid_word", word_count, 0);
    tick();
    rst = 1'b0;
    we0 = we_cnt; tx0 = tx_cnt;
    send_frame(vecs[0].cmd, vecs[0].addr, vecs[0].data, vecs[0].csum);
    repeat (5) tick();
    check("post_rst_we", we_cnt - we0, 1);
    check("post_rst_tx", tx_cnt - tx0, 1);
    check("post_rst_ack", last_tx, 8'h06);

    // Error counter saturation.
    repeat (256) begin
      send_frame(8'h03, 32'h0, 32'h0, 8'h03);
      repeat (2) tick();
    end
    check("err_saturate", err_count, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/boot_mem_uart_loader.md
Name: boot_mem_uart_loader

Overview:
Loads the boot memory image over the system UART instead of at elaboration time. It parses framed write commands from the UART receive byte stream and writes 32-bit words into the boot memory write port. It acknowledges each frame on the UART transmit path. It holds the CPU in reset until a GO frame arrives, so the same image flow works on hardware and in simulation.

Parameters:
MEM_AW, 11, boot memory word-address width (8 KB, byte address bits [12:2])
TIMEOUT_CYCLES, 80000, inter-byte timeout inside a frame (1 ms at 80 MHz)
SYNC_BYTE, 8'hA5, frame start marker

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset, asynchronous, active-high
i_rx_valid  in  1  one-cycle strobe, received byte valid (no backpressure)
i_rx_data  in  8  received byte
o_tx_valid  out  1  response byte valid
o_tx_data  out  8  response byte
i_tx_ready  in  1  UART TX accepts byte when high together with o_tx_valid
o_mem_we  out  1  boot memory write strobe, one cycle
o_mem_addr  out  MEM_AW  word address
o_mem_wdata  out  32  write data
o_cpu_hold  out  1  holds CPU in reset while high
o_busy  out  1  high in any state other than IDLE and RUN
o_word_count  out  16  words written, wraps
o_err_count  out  8  rejected or timed-out frames, saturates at 255

Behaviour:
- Reset values:
  - o_cpu_hold=1.
  - All other outputs 0.
  - State IDLE, all counters 0.
- Frame format, 11 bytes:
  - SYNC, CMD, ADDR[31:24..7:0] (big-endian), DATA[31:24..7:0] (big-endian), CSUM.
  - CSUM is the XOR of CMD, the 4 ADDR bytes and the 4 DATA bytes.
- Commands:
  - 0x01 = WRITE.
  - 0x02 = GO; ADDR and DATA are ignored but must be sent.
  - Any other CMD value is rejected with NAK.
- States and transitions:
  - IDLE: a byte equal to SYNC_BYTE -> CMD; any other byte is discarded.
  - CMD -> ADDR. ADDR collects 4 bytes using a 2-bit index, then -> DATA. DATA collects 4 bytes, then -> CSUM.
  - CSUM byte accepted in cycle N, frame valid WRITE: WRITE state in N+1 with o_mem_we=1 for exactly that cycle. o_mem_addr=ADDR[MEM_AW+1:2], o_mem_wdata=DATA. o_word_count increments in the same cycle. RESP in N+2 with ACK 0x06.
  - CSUM byte accepted in cycle N, frame valid GO: RESP in N+1 with ACK 0x06. After the handshake -> RUN. o_cpu_hold falls in the cycle after the handshake.
  - CSUM byte accepted in cycle N, frame invalid: RESP in N+1 with NAK 0x15, and o_err_count increments.
    - Invalid means any of: bad checksum; unknown CMD; WRITE with ADDR[31:MEM_AW+2]!=0 or ADDR[1:0]!=0.
  - RESP: o_tx_valid and o_tx_data are held stable until i_tx_ready=1. The handshake cycle drops o_tx_valid next cycle and goes -> IDLE (or -> RUN after GO).
  - RUN: terminal until reset. All rx bytes are ignored and o_mem_we stays 0.
- Boundary conditions:
  - Bytes arriving in WRITE or RESP are dropped; the host must wait for the response byte.
  - Timeout counter:
    - Clears on every accepted rx byte and runs only in CMD through CSUM.
    - Reaching TIMEOUT_CYCLES-1 forces -> IDLE and increments o_err_count.
    - No response byte is sent, and the partial frame is discarded.
  - A SYNC value inside the payload is treated as data (no resync mid-frame).
  - o_word_count wraps from 0xFFFF to 0.
  - o_err_count holds at 0xFF.
  - Async reset mid-frame or mid-RESP returns every output to its reset value immediately. This re-asserts o_cpu_hold even from RUN.

Decomposition:
- Package boot_loader_pkg:
  - Constants: SYNC default, CMD_WRITE=0x01, CMD_GO=0x02, ACK=0x06, NAK=0x15.
  - State enum: IDLE, CMD, ADDR, DATA, CSUM, WRITE, RESP, RUN.
- One sub-module, loader_timeout: counter with clear and enable inputs and an expired pulse output, parameterised by TIMEOUT_CYCLES.
- Frame shift registers, checksum and FSM stay in the top module.

Test Plan:
1. WRITE frame A5 01 00 00 00 10 E3 A0 00 00 52 -> one-cycle o_mem_we with o_mem_addr=4 and o_mem_wdata=0xE3A00000; o_tx_data=0x06; o_word_count=1.
2. Same frame with CSUM=0x53 -> no o_mem_we; NAK 0x15; o_err_count=1; o_word_count unchanged.
3. WRITE to 0x00002000 (checksum correct) -> NAK; no write. WRITE to 0x00000002 -> NAK.
4. Send A5 01 00 then idle 80000 cycles -> back to IDLE; no tx; o_err_count+1. A following valid frame is ACKed normally.
5. GO frame A5 02 00 00 00 00 00 00 00 00 02 with i_tx_ready low for 10 cycles -> o_tx_valid and 0x06 held stable. o_cpu_hold falls the cycle after ready. A subsequent WRITE frame produces no write and no tx.
6. Assert i_rst during the DATA bytes -> o_busy=0 and o_cpu_hold=1 at once. A full valid frame after deassertion is ACKed.
